// File: rtl/fb_axis_reader.sv
// Frame-buffer read-out engine: walks a 12-bit frame RAM in raster order and emits an AXI4-Stream video master.
// Optional AUTO_REPEAT_EN: frames restart back-to-back until a latched stop completes the current frame.
module fb_axis_reader #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              Cclk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [11:0]       mem_rd_data,
  output logic [23:0]       m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast
);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  typedef struct packed {
    logic eof;
    logic last;
    logic user;
  } tag_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_issue_done;
  logic              r_inflight;
  tag_t              r_infl_tag;
  logic [11:0]       r_fifo_d   [2];
  tag_t              r_fifo_tag [2];
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;
  logic              r_frame_done;

  logic        w_valid, w_pop, w_rd, w_stopping, w_final, w_end;
  tag_t        w_issue_tag, w_head_tag;
  logic [11:0] w_head_d;

`ifdef AUTO_REPEAT_EN
  logic r_stop;
  assign w_stopping = r_stop || stop;
`else
  logic w_unused_stop;
  assign w_unused_stop = stop;
  assign w_stopping    = 1'b1;
`endif

  assign w_valid    = (r_cnt != 2'd0);
  assign w_pop      = w_valid && m_axis_video_tready;
  assign w_head_d   = r_fifo_d[r_rp];
  assign w_head_tag = r_fifo_tag[r_rp];

  // Occupancy plus the read in flight never exceeds the 2-entry FIFO.
  assign w_rd = (r_state == S_STREAM) && !r_issue_done &&
                (((r_cnt + {1'b0, r_inflight}) < 2'd2) || w_pop);

  assign w_issue_tag.eof  = (r_x == X_MAX) && (r_y == Y_MAX);
  assign w_issue_tag.last = (r_x == X_MAX);
  assign w_issue_tag.user = (r_x == '0) && (r_y == '0);

  assign w_final = w_pop && w_head_tag.eof;
  assign w_end   = w_final && w_stopping;

  always_ff @(posedge Cclk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_issue_done  <= 1'b0;
      r_inflight    <= 1'b0;
      r_infl_tag    <= '0;
      r_fifo_d[0]   <= '0;
      r_fifo_d[1]   <= '0;
      r_fifo_tag[0] <= '0;
      r_fifo_tag[1] <= '0;
      r_wp          <= 1'b0;
      r_rp          <= 1'b0;
      r_cnt         <= '0;
      r_frame_done  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_stop        <= 1'b0;
`endif
    end else begin
      r_frame_done <= (r_state == S_STREAM) && w_final;
      case (r_state)
        S_IDLE: if (start) r_state <= S_STREAM;
        S_STREAM: begin
          if (w_end) begin
            // Anything already fetched for a following frame is dropped here.
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_issue_done <= 1'b0;
            r_inflight   <= 1'b0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
          end else begin
            r_inflight <= w_rd;
            if (w_rd) begin
              r_infl_tag <= w_issue_tag;
              r_addr     <= w_issue_tag.eof ? '0 : r_addr + ADDR_W'(1);
              r_x        <= w_issue_tag.last ? '0 : r_x + XW'(1);
              if (w_issue_tag.last) r_y <= w_issue_tag.eof ? '0 : r_y + YW'(1);
              if (w_issue_tag.eof && w_stopping) r_issue_done <= 1'b1;
            end
            if (r_inflight) begin
              r_fifo_d[r_wp]   <= mem_rd_data;
              r_fifo_tag[r_wp] <= r_infl_tag;
              r_wp             <= !r_wp;
            end
            if (w_pop) r_rp <= !r_rp;
            r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef AUTO_REPEAT_EN
      if (r_state == S_STREAM) begin
        if (w_end)     r_stop <= 1'b0;
        else if (stop) r_stop <= 1'b1;
      end
`endif
    end
  end

  assign busy                = (r_state == S_STREAM);
  assign frame_done          = r_frame_done;
  assign mem_rd_en           = w_rd;
  assign mem_rd_addr         = r_addr;
  assign m_axis_video_tvalid = w_valid;
  assign m_axis_video_tuser  = w_head_tag.user;
  assign m_axis_video_tlast  = w_head_tag.last;
  assign m_axis_video_tdata  = {{2{w_head_d[11:8]}}, {2{w_head_d[7:4]}}, {2{w_head_d[3:0]}}};
endmodule

// File: tb/tb_fb_axis_reader.sv
// Self-checking bench for fb_axis_reader on a 4x2 frame; reference model tracks beats, reads and frame state.
module tb_fb_axis_reader;
  localparam int H = 4, V = 2, AW = 3, TOT = H * V;

  logic          Cclk = 1'b0;
  logic          rst, start, stop, busy, frame_done, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [11:0]   mem_rd_data;
  logic [23:0]   tdata;
  logic          tvalid, tready, tuser, tlast;

  always #5 Cclk = ~Cclk;

  fb_axis_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .Cclk(Cclk), .rst(rst), .start(start), .stop(stop), .busy(busy),
    .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .m_axis_video_tdata(tdata),
    .m_axis_video_tvalid(tvalid), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast)
  );

  logic [11:0] ram [TOT];
  always @(posedge Cclk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  int checks = 0, errs = 0, cyc_no = 0;
  int beat, rd_idx, issued, accepted, frames, fd_seen, s0;
  bit running, fd_exp, stop_lat, prev_stall, prev_rs, sent;
  bit s_rd, s_valid, s_busy, s_fd;
  logic [25:0] prev_word;
  logic [25:0] acc_word [64];
  int          acc_cyc  [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {tuser,tlast,tdata} for raster index i, from the pixel rules.
  function automatic logic [25:0] exp_word(input int i);
    logic [11:0] d;
    logic [7:0]  r8, g8, b8;
    d  = ram[i];
    r8 = 8'({4'h0, d[11:8]} * 8'd17);
    g8 = 8'({4'h0, d[7:4]}  * 8'd17);
    b8 = 8'({4'h0, d[3:0]}  * 8'd17);
    return {(i == 0), ((i % H) == H - 1), r8, g8, b8};
  endfunction

  task automatic cyc(input bit rdy, input bit st, input bit sp, input bit rs);
    logic [25:0] word;
    int idx;
    tready = rdy; start = st; stop = sp; rst = rs;
    #1;
    word = {tuser, tlast, tdata};
    s_rd = mem_rd_en; s_valid = tvalid; s_busy = busy; s_fd = frame_done;
    if (rs) begin
      if (prev_rs)
        chk("rst_outputs", 64'({tvalid, tuser, tlast, tdata, mem_rd_en, mem_rd_addr, busy, frame_done}), 64'd0);
      running = 0; beat = 0; rd_idx = 0; issued = 0; accepted = 0;
      fd_exp = 0; stop_lat = 0; prev_stall = 0;
    end else begin
      if (frame_done) fd_seen++;
      chk("frame_done", 64'(frame_done), 64'(fd_exp));
      fd_exp = 0;
      chk("busy", 64'(busy), 64'(running));
      if (!running) chk("idle_tvalid", 64'(tvalid), 64'd0);
      if (prev_stall) begin
        chk("stall_tvalid", 64'(tvalid), 64'd1);
        chk("stall_hold", 64'(word), 64'(prev_word));
      end
      if (running) chk("outstanding_le2", 64'(issued - accepted <= 2), 64'd1);
      if (mem_rd_en) begin
        chk("rd_addr", 64'(mem_rd_addr), 64'(rd_idx % TOT));
`ifndef AUTO_REPEAT_EN
        chk("rd_in_frame", 64'(rd_idx < TOT), 64'd1);
`endif
        rd_idx++; issued++;
      end
      if (st && !running) begin
        running = 1; beat = 0; rd_idx = 0; issued = 0; accepted = 0; stop_lat = 0;
      end
      if (sp && running) stop_lat = 1;
      if (tvalid && rdy) begin
        idx = beat % TOT;
        chk("beat_word", 64'(word), 64'(exp_word(idx)));
        if (beat < 64) begin acc_word[beat] = word; acc_cyc[beat] = cyc_no; end
        beat++; accepted++;
        if (idx == TOT - 1) begin
          fd_exp = 1; frames++;
`ifdef AUTO_REPEAT_EN
          running = !stop_lat;
`else
          running = 0;
`endif
          if (!running) begin stop_lat = 0; issued = 0; accepted = 0; end
        end
      end
      prev_stall = tvalid && !rdy;
      prev_word  = word;
    end
    prev_rs = rs;
    cyc_no++;
    @(posedge Cclk);
    #1;
  endtask

  task automatic run_until_idle(input int mode, input int budget);
    int k;
    bit r;
    k = 0;
    do begin
      if (mode == 0)      r = 1;
      else if (mode == 1) r = (k < 2) ? 1'b1 : (k < 6) ? ((k - 2) % 2 == 0) : (k < 11) ? 1'b0 : 1'b1;
      else                r = ($urandom_range(0, 3) != 0);
      cyc(r, 0, 0, 0);
      k++;
    end while (running && k < budget);
    chk("frame_timeout", 64'(running), 64'd0);
    cyc(1, 0, 0, 0);
  endtask

  initial begin
    tready = 0; start = 0; stop = 0; rst = 1;
    beat = 0; rd_idx = 0; issued = 0; accepted = 0; frames = 0; fd_seen = 0;
    running = 0; fd_exp = 0; stop_lat = 0; prev_stall = 0; prev_rs = 0; sent = 0;
    for (int i = 0; i < TOT; i++) ram[i] = 12'h1A0 + 12'(i);

    repeat (3) cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    chk("post_rst_zero", 64'({tvalid, tuser, tlast, tdata, mem_rd_en, mem_rd_addr, busy, frame_done}), 64'd0);

`ifndef AUTO_REPEAT_EN
    s0 = cyc_no;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("first_rd_en", 64'(s_rd), 64'd1);
    chk("busy_rise", 64'(s_busy), 64'd1);
    chk("tvalid_early", 64'(s_valid), 64'd0);
    cyc(1, 0, 0, 0);
    chk("tvalid_e1", 64'(s_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, i == 3, 0, 0);
      chk("throughput", 64'(s_valid), 64'd1);
    end
    cyc(1, 0, 0, 0);
    chk("done_pulse", 64'(s_fd), 64'd1);
    chk("busy_fall", 64'(s_busy), 64'd0);
    chk("first_beat_lat", 64'(acc_cyc[0]), 64'(s0 + 3));
    chk("beats_consec", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    chk("beat0_word", 64'(acc_word[0]), 64'h2_11AA00);
    chk("tlast_b3", 64'(acc_word[3][24]), 64'd1);
    chk("frames_1", 64'(frames), 64'd1);

    cyc(1, 1, 0, 0);
    run_until_idle(1, 100);
    chk("stall_beats", 64'(beat), 64'd8);
    chk("frames_2", 64'(frames), 64'd2);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < TOT; i++) ram[i] = 12'($urandom);
      cyc($urandom_range(0, 1) == 1, 1, 0, 0);
      run_until_idle(2, 300);
      chk("rand_beats", 64'(beat), 64'd8);
    end

    cyc(1, 1, 0, 0);
    for (int c = 0; c < 50 && beat < 5; c++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("rst_mid_tvalid", 64'(s_valid), 64'd0);
    chk("rst_mid_busy", 64'(s_busy), 64'd0);
    cyc(1, 1, 0, 0);
    run_until_idle(0, 50);
    chk("after_rst_beats", 64'(beat), 64'd8);
    chk("after_rst_tuser", 64'(acc_word[0][25]), 64'd1);
    chk("fd_total", 64'(fd_seen), 64'(frames));
`else
    fd_seen = 0;
    for (int c = 0; c < 200 && (c == 0 || running); c++) begin
      cyc(1, c == 0, beat == 10 && !sent, 0);
      if (beat == 10) sent = 1;
    end
    chk("repeat_timeout", 64'(running), 64'd0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("repeat_frames", 64'(frames), 64'd2);
    chk("repeat_fd", 64'(fd_seen), 64'd2);
    chk("repeat_beats", 64'(beat), 64'd16);
    chk("repeat_nogap", 64'(acc_cyc[8] - acc_cyc[7]), 64'd1);
    chk("repeat_span", 64'(acc_cyc[15] - acc_cyc[0]), 64'd15);
    chk("repeat_tuser8", 64'(acc_word[8][25]), 64'd1);
    chk("repeat_idle", 64'(s_busy), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
